// File: rtl/unified_mem_arbiter_pkg.sv
// Shared constants and FSM encoding for the unified instruction/data memory arbiter.
package unified_mem_arbiter_pkg;

  localparam logic       RstEnable = 1'b1;
  localparam int         StallIfId = 1;
  localparam int         StallMem  = 4;
  localparam logic [3:0] SelAll    = 4'b1111;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    DATA_BUSY = 2'd1,
    INST_BUSY = 2'd2
  } arb_state_e;

endpackage

// File: rtl/unified_mem_arbiter_if.sv
// Request/acknowledge bus between the arbiter (master) and the single-ported memory (slave).
interface unified_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              req;
  logic              we;
  logic [3:0]        sel;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ack;
  logic [DATA_W-1:0] rdata;

  modport master (output req, we, sel, addr, wdata, input ack, rdata);
  modport slave  (input req, we, sel, addr, wdata, output ack, rdata);

endinterface

// File: rtl/unified_mem_arbiter.sv
// Serialises instruction fetches and data accesses onto one memory port,
// holding returned read data until the pipeline consumes it.
module unified_mem_arbiter
  import unified_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [5:0]            stall_i,
  input  logic                  inst_ce_i,
  input  logic [ADDR_W-1:0]     inst_addr_i,
  output logic [DATA_W-1:0]     inst_data_o,
  output logic                  stallreq_inst_o,
  input  logic                  data_ce_i,
  input  logic                  data_we_i,
  input  logic [3:0]            data_sel_i,
  input  logic [ADDR_W-1:0]     data_addr_i,
  input  logic [DATA_W-1:0]     data_wdata_i,
  output logic [DATA_W-1:0]     data_rdata_o,
  output logic                  stallreq_data_o,
  unified_mem_arbiter_if.master mem
);

  arb_state_e        state_q, state_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [3:0]        sel_q, sel_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] inst_buf_q, inst_buf_d;
  logic [DATA_W-1:0] data_buf_q, data_buf_d;
  logic              inst_done_q, inst_done_d;
  logic              data_done_q, data_done_d;
  logic              inst_pending, data_pending;
  logic              unused_stall;

  assign unused_stall = ^{stall_i[5], stall_i[3:2], stall_i[0]};

  assign inst_pending    = inst_ce_i & ~inst_done_q;
  assign data_pending    = data_ce_i & ~data_done_q;
  assign stallreq_inst_o = (rst != RstEnable) & inst_pending;
  assign stallreq_data_o = (rst != RstEnable) & data_pending;

  assign mem.req      = req_q;
  assign mem.we       = we_q;
  assign mem.sel      = sel_q;
  assign mem.addr     = addr_q;
  assign mem.wdata    = wdata_q;
  assign inst_data_o  = inst_buf_q;
  assign data_rdata_o = data_buf_q;

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    we_d        = we_q;
    sel_d       = sel_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    inst_buf_d  = inst_buf_q;
    data_buf_d  = data_buf_q;
    inst_done_d = inst_done_q;
    data_done_d = data_done_q;

    // A done flag only retires once its pipeline stage is free to take the buffer.
    if (inst_done_q && !stall_i[StallIfId]) inst_done_d = 1'b0;
    if (data_done_q && !stall_i[StallMem])  data_done_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (data_pending) begin
          req_d   = 1'b1;
          we_d    = data_we_i;
          sel_d   = data_sel_i;
          addr_d  = data_addr_i;
          wdata_d = data_wdata_i;
          state_d = DATA_BUSY;
        end else if (inst_pending) begin
          req_d   = 1'b1;
          we_d    = 1'b0;
          sel_d   = SelAll;
          addr_d  = inst_addr_i;
          state_d = INST_BUSY;
        end
      end
      DATA_BUSY: begin
        if (mem.ack) begin
          req_d       = 1'b0;
          we_d        = 1'b0;
          data_done_d = 1'b1;
          if (!we_q) data_buf_d = mem.rdata;
          state_d     = IDLE;
        end
      end
      INST_BUSY: begin
        if (mem.ack) begin
          req_d       = 1'b0;
          we_d        = 1'b0;
          inst_done_d = 1'b1;
          inst_buf_d  = mem.rdata;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state_q     <= IDLE;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      sel_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      inst_buf_q  <= '0;
      data_buf_q  <= '0;
      inst_done_q <= 1'b0;
      data_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      we_q        <= we_d;
      sel_q       <= sel_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      inst_buf_q  <= inst_buf_d;
      data_buf_q  <= data_buf_d;
      inst_done_q <= inst_done_d;
      data_done_q <= data_done_d;
    end
  end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Bench for unified_mem_arbiter: a latency-programmable memory model, a simple ctrl
// stall model and per-scenario tasks checking timing, bus fields and buffers.
module tb_unified_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_ce_i;
  logic [31:0] inst_addr_i;
  logic [31:0] inst_data_o;
  logic        stallreq_inst_o;
  logic        data_ce_i;
  logic        data_we_i;
  logic [3:0]  data_sel_i;
  logic [31:0] data_addr_i;
  logic [31:0] data_wdata_i;
  logic [31:0] data_rdata_o;
  logic        stallreq_data_o;
  logic        manual_en;
  logic [5:0]  manual_stall;
  wire  [5:0]  stall_i;

  int          lat;
  int          n_cmp;
  int          n_err;
  logic [31:0] mem [logic [31:0]];
  logic [31:0] exp_inst_buf;
  logic [31:0] exp_data_buf;

  unified_mem_arbiter_if bus ();

  unified_mem_arbiter dut (
    .clk             (clk),
    .rst             (rst),
    .stall_i         (stall_i),
    .inst_ce_i       (inst_ce_i),
    .inst_addr_i     (inst_addr_i),
    .inst_data_o     (inst_data_o),
    .stallreq_inst_o (stallreq_inst_o),
    .data_ce_i       (data_ce_i),
    .data_we_i       (data_we_i),
    .data_sel_i      (data_sel_i),
    .data_addr_i     (data_addr_i),
    .data_wdata_i    (data_wdata_i),
    .data_rdata_o    (data_rdata_o),
    .stallreq_data_o (stallreq_data_o),
    .mem             (bus)
  );

  always #5 clk = ~clk;

  // ctrl model: a MEM-stage stall freezes everything up to MEM/WB, a fetch stall only IF/ID.
  assign stall_i = manual_en ? manual_stall :
                   (stallreq_data_o ? 6'b011111 : (stallreq_inst_o ? 6'b000011 : 6'b000000));

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  function automatic void mem_write(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
    logic [31:0] w;
    w = mem_word(a);
    for (int b = 0; b < 4; b++) if (s[b]) w[8*b +: 8] = d[8*b +: 8];
    mem[a] = w;
  endfunction

  // Memory: accepts a request when first seen, acks after 'lat' further cycles even if req drops.
  initial begin
    bit          busy;
    int          rem;
    logic        w;
    logic [3:0]  s;
    logic [31:0] a, wd;
    busy = 0;
    rem = 0;
    w = 0; s = 0; a = 0; wd = 0;
    bus.ack   = 1'b0;
    bus.rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.ack) begin
        bus.ack = 1'b0;
      end else begin
        if (!busy && bus.req) begin
          a = bus.addr; w = bus.we; s = bus.sel; wd = bus.wdata;
          busy = 1;
          rem = lat + 1;
        end
        if (busy) begin
          rem--;
          if (rem <= 0) begin
            if (w) begin
              mem_write(a, s, wd);
              bus.rdata = $urandom;
            end else begin
              bus.rdata = mem_word(a);
            end
            bus.ack = 1'b1;
            busy = 0;
          end
        end
      end
    end
  end

  // Presents one or two requests and follows them to completion; expected stall-drop cycles
  // come from the access latency: lat+2 per access, fetch queued behind the data access.
  task automatic run_access(input bit do_inst, input logic [31:0] iaddr, input bit hold_inst,
                            input bit do_data, input bit we, input logic [3:0] sel,
                            input logic [31:0] daddr, input logic [31:0] wdata,
                            input int latency, input string tag);
    int   exp_d_drop, exp_i_drop;
    bit   d_pend, i_pend, drop_d, drop_i, served_data;
    logic [31:0] ea;
    logic [3:0]  es;
    logic        ew;
    lat = latency;
    exp_d_drop = latency + 2;
    exp_i_drop = do_data ? 2 * (latency + 2) : latency + 2;
    d_pend = do_data;
    i_pend = do_inst;
    drop_d = 0;
    drop_i = 0;
    inst_ce_i = do_inst;
    inst_addr_i = iaddr;
    data_ce_i = do_data;
    data_we_i = we;
    data_sel_i = sel;
    data_addr_i = daddr;
    data_wdata_i = wdata;
    for (int c = 0; c < 64 && (d_pend || i_pend); c++) begin
      @(negedge clk);
      if (bus.req) begin
        served_data = d_pend;
        ea = served_data ? daddr : iaddr;
        ew = served_data ? we : 1'b0;
        es = served_data ? sel : 4'b1111;
        n_cmp++;
        if ({bus.addr, bus.we, bus.sel} !== {ea, ew, es}) begin
          n_err++;
          $display("[TB] FAIL %s bus_fields: got addr=%h we=%b sel=%b, need addr=%h we=%b sel=%b",
                   tag, bus.addr, bus.we, bus.sel, ea, ew, es);
        end
        if (served_data && we) begin
          n_cmp++;
          if (bus.wdata !== wdata) begin
            n_err++;
            $display("[TB] FAIL %s bus_wdata: got %h, need %h", tag, bus.wdata, wdata);
          end
        end
      end
      if (d_pend && !stallreq_data_o) begin
        d_pend = 0;
        drop_d = 1;
        if (!we) exp_data_buf = mem_word(daddr);
        n_cmp++;
        if (c != exp_d_drop) begin
          n_err++;
          $display("[TB] FAIL %s data_stall_drop: got cycle %0d, need %0d", tag, c, exp_d_drop);
        end
        n_cmp++;
        if (data_rdata_o !== exp_data_buf) begin
          n_err++;
          $display("[TB] FAIL %s data_rdata: got %h, need %h", tag, data_rdata_o, exp_data_buf);
        end
      end
      if (i_pend && !stallreq_inst_o) begin
        i_pend = 0;
        drop_i = !hold_inst;
        exp_inst_buf = mem_word(iaddr);
        n_cmp++;
        if (c != exp_i_drop) begin
          n_err++;
          $display("[TB] FAIL %s inst_stall_drop: got cycle %0d, need %0d", tag, c, exp_i_drop);
        end
        n_cmp++;
        if (inst_data_o !== exp_inst_buf) begin
          n_err++;
          $display("[TB] FAIL %s inst_data: got %h, need %h", tag, inst_data_o, exp_inst_buf);
        end
      end
      @(posedge clk);
      #1;
      if (drop_d) data_ce_i = 1'b0;
      if (drop_i) inst_ce_i = 1'b0;
    end
    if (d_pend || i_pend) begin
      n_cmp++;
      n_err++;
      $display("[TB] FAIL %s timeout: got pending data=%b inst=%b, need both served", tag, d_pend, i_pend);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    inst_ce_i = 1'b1;
    data_ce_i = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({stallreq_inst_o, stallreq_data_o} !== 2'b00) begin
      n_err++;
      $display("[TB] FAIL reset_stalls: got %b, need 00", {stallreq_inst_o, stallreq_data_o});
    end
    n_cmp++;
    if ({bus.req, bus.we, bus.sel, bus.addr, bus.wdata} !== '0) begin
      n_err++;
      $display("[TB] FAIL reset_bus: got req=%b we=%b sel=%b addr=%h wdata=%h, need all 0",
               bus.req, bus.we, bus.sel, bus.addr, bus.wdata);
    end
    n_cmp++;
    if ({inst_data_o, data_rdata_o} !== 64'd0) begin
      n_err++;
      $display("[TB] FAIL reset_buffers: got %h %h, need 0 0", inst_data_o, data_rdata_o);
    end
    @(posedge clk);
    #1;
    inst_ce_i = 1'b0;
    data_ce_i = 1'b0;
    rst = 1'b0;
    exp_inst_buf = '0;
    exp_data_buf = '0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_fetch_only();
    run_access(1, 32'h100, 0, 0, 0, 4'h0, 32'h0, 32'h0, 1, "fetch_only");
    n_cmp++;
    if (inst_data_o !== 32'h3C010101) begin
      n_err++;
      $display("[TB] FAIL fetch_only_value: got %h, need 3c010101", inst_data_o);
    end
  endtask

  task automatic test_simultaneous();
    run_access(1, 32'h104, 0, 1, 0, 4'hF, 32'h200, 32'h0, 1, "simultaneous");
  endtask

  task automatic test_store();
    logic [31:0] prior, prior2, keep;
    prior = mem_word(32'h300);
    keep = data_rdata_o;
    run_access(0, 32'h0, 0, 1, 1, 4'b0011, 32'h300, 32'hDEADBEEF, 2, "store");
    n_cmp++;
    if (data_rdata_o !== keep) begin
      n_err++;
      $display("[TB] FAIL store_rdata_kept: got %h, need %h", data_rdata_o, keep);
    end
    run_access(0, 32'h0, 0, 1, 0, 4'hF, 32'h300, 32'h0, 0, "store_readback");
    n_cmp++;
    if (data_rdata_o !== {prior[31:16], 16'hBEEF}) begin
      n_err++;
      $display("[TB] FAIL store_merge: got %h, need %h", data_rdata_o, {prior[31:16], 16'hBEEF});
    end
    prior2 = mem_word(32'h304);
    run_access(0, 32'h0, 0, 1, 1, 4'b0000, 32'h304, 32'h12345678, 1, "store_sel0");
    run_access(0, 32'h0, 0, 1, 0, 4'hF, 32'h304, 32'h0, 0, "store_sel0_readback");
    n_cmp++;
    if (data_rdata_o !== prior2) begin
      n_err++;
      $display("[TB] FAIL store_sel0_unchanged: got %h, need %h", data_rdata_o, prior2);
    end
  endtask

  task automatic test_fetch_hold();
    manual_en = 1'b1;
    manual_stall = 6'b000010;
    run_access(1, 32'h108, 1, 0, 0, 4'h0, 32'h0, 32'h0, 0, "fetch_hold");
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({bus.req, stallreq_inst_o, inst_data_o} !== {1'b0, 1'b0, exp_inst_buf}) begin
        n_err++;
        $display("[TB] FAIL fetch_hold_cycle%0d: got req=%b stall=%b data=%h, need 0 0 %h",
                 i, bus.req, stallreq_inst_o, inst_data_o, exp_inst_buf);
      end
      @(posedge clk);
      #1;
    end
    manual_stall = 6'b000000;
    @(negedge clk);
    n_cmp++;
    if (stallreq_inst_o !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL fetch_hold_release: got stall=%b, need 0", stallreq_inst_o);
    end
    @(posedge clk);
    #1;
    manual_en = 1'b0;
    run_access(1, 32'h10C, 0, 0, 0, 4'h0, 32'h0, 32'h0, 1, "fetch_after_hold");
  endtask

  task automatic test_reset_mid_access();
    lat = 1;
    inst_ce_i = 1'b1;
    inst_addr_i = 32'h180;
    @(posedge clk);
    #1;
    @(negedge clk);
    n_cmp++;
    if (bus.req !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL reset_mid_busy: got req=%b, need 1", bus.req);
    end
    rst = 1'b1;
    inst_ce_i = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_inst_buf = '0;
    exp_data_buf = '0;
    @(negedge clk);
    n_cmp++;
    if ({bus.req, inst_data_o, data_rdata_o} !== 65'd0) begin
      n_err++;
      $display("[TB] FAIL reset_mid_clear: got req=%b inst=%h data=%h, need 0 0 0",
               bus.req, inst_data_o, data_rdata_o);
    end
    @(posedge clk);
    #1;
    @(negedge clk);
    n_cmp++;
    if ({bus.req, inst_data_o} !== 33'd0) begin
      n_err++;
      $display("[TB] FAIL reset_late_ack: got req=%b inst=%h, need 0 0", bus.req, inst_data_o);
    end
    @(posedge clk);
    #1;
    run_access(1, 32'h180, 0, 0, 0, 4'h0, 32'h0, 32'h0, 2, "after_reset");
  endtask

  task automatic test_flush();
    lat = 2;
    data_ce_i = 1'b1;
    data_we_i = 1'b0;
    data_sel_i = 4'hF;
    data_addr_i = 32'h40;
    @(posedge clk);
    #1;
    data_ce_i = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    exp_data_buf = mem_word(32'h40);
    n_cmp++;
    if ({bus.req, stallreq_data_o, data_rdata_o} !== {1'b0, 1'b0, exp_data_buf}) begin
      n_err++;
      $display("[TB] FAIL flush_complete: got req=%b stall=%b data=%h, need 0 0 %h",
               bus.req, stallreq_data_o, data_rdata_o, exp_data_buf);
    end
    @(posedge clk);
    #1;
    run_access(0, 32'h0, 0, 1, 0, 4'hF, 32'h44, 32'h0, 0, "after_flush");
  endtask

  task automatic test_back_to_back();
    run_access(0, 32'h0, 0, 1, 0, 4'hF, 32'h10, 32'h0, 0, "b2b_first");
    run_access(0, 32'h0, 0, 1, 0, 4'hF, 32'h14, 32'h0, 0, "b2b_second");
  endtask

  task automatic test_random();
    int          kind;
    logic [31:0] ia, da;
    for (int n = 0; n < 24; n++) begin
      kind = $urandom_range(0, 3);
      ia = 32'h1000 + 32'($urandom_range(0, 7)) * 4;
      da = 32'h1000 + 32'($urandom_range(0, 7)) * 4;
      run_access(kind == 0 || kind == 3, ia, 0, kind != 0, kind == 2 || (kind == 3 && $urandom_range(0, 1) == 1),
                 4'($urandom_range(0, 15)), da, $urandom, $urandom_range(0, 3),
                 $sformatf("random%0d", n));
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    lat = 0;
    rst = 1'b1;
    manual_en = 1'b0;
    manual_stall = '0;
    inst_ce_i = 1'b0;
    inst_addr_i = '0;
    data_ce_i = 1'b0;
    data_we_i = 1'b0;
    data_sel_i = '0;
    data_addr_i = '0;
    data_wdata_i = '0;
    exp_inst_buf = '0;
    exp_data_buf = '0;
    mem[32'h100] = 32'h3C010101;
    @(posedge clk);
    #1;
    test_reset();
    test_fetch_only();
    test_simultaneous();
    test_store();
    test_fetch_hold();
    test_reset_mid_access();
    test_flush();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
